vector_vector_alu_sat: RTL and testbench
========================================

VECTOR_VECTOR_ALU_SAT -- requirements
Module: vector_vector_alu_sat

Interface
REQ-001 SHALL have parameter N, default 8: vector lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: lane width, signed two's complement.
REQ-003 SHALL have parameter FRAC_BITS, default 16: fractional bits; 0 means integer mode.
REQ-004 SHALL have parameter MAX_CHAINS, default 4: firmware entries, indexed by chainId.
REQ-005 SHALL have parameter VRF_SIZE, default 8: vector register file depth, power of two.
REQ-006 SHALL have parameter PERSONAL_CONFIG_ID, default 0: configId value that selects this block.
REQ-007 SHALL have parameter SATURATE, default 1: 1 means saturate arithmetic, 0 means wrap.
REQ-008 SHALL have these ports: clk in 1: clock; reset in 1: asynchronous, active-high.
REQ-009 SHALL have: tracing in 1: 1 = process data, 0 = configuration mode; valid_in in 1; eof_in in 2; bof_in in 2; chainId_in in clog2(MAX_CHAINS).
REQ-010 SHALL have: configId in 8; configData in 8: config byte stream.
REQ-011 SHALL have: vector_in in N x DATA_WIDTH; vector_out out N x DATA_WIDTH.
REQ-012 SHALL have: valid_out out 1; eof_out out 2; bof_out out 2; chainId_out out clog2(MAX_CHAINS).
REQ-013 SHALL have: overflow_out out N: per-lane flag, 1 when that lane's result saturated or wrapped.

Function
REQ-014 SHALL be a 2-stage pipeline; inputs accepted in cycle t appear on the outputs in cycle t+2; no stalls; one vector accepted per cycle.
REQ-015 Stage 1 SHALL register the vector, valid, eof, bof, chainId and firmware[chainId_in] (op, addr_rd, cond, cache, cache_addr).
REQ-016 Stage 2 SHALL read operand = VRF[addr_rd] combinationally, compute the result, and register all outputs.
REQ-017 Ops SHALL be: 0 pass, 1 add, 2 mul, 3 sub (in-operand), 4 signed max, 5 signed min, 6 absolute difference; codes 7-255 SHALL pass through.
REQ-018 mul SHALL form the full 2*DATA_WIDTH signed product, arithmetic-shift it right by FRAC_BITS (truncation toward minus infinity), then saturate or wrap.
REQ-019 Saturation bounds SHALL be -2^(DATA_WIDTH-1) and 2^(DATA_WIDTH-1)-1; overflow_out[i] SHALL be 1 only when op is 1/2/3/6, cond holds and lane i's exact result is outside these bounds.
REQ-020 Cond SHALL be: 0 always; 1/2 eof[0] equal to 1/0; 3/4 bof[0] equal to 1/0; 5/6 eof[1] equal to 1/0; 7/8 bof[1] equal to 1/0; other codes never hold.
REQ-021 If cond is false, the result SHALL be the stage-1 vector unchanged and overflow_out SHALL be 0.
REQ-022 When the stage-2 valid is 1 and cache is nonzero, the result SHALL be written to VRF[cache_addr] at the clock edge that registers the outputs; the write SHALL occur even if cond is false.
REQ-023 A read in cycle t+1 of an address written at edge t SHALL return the new data (back-to-back accumulation).
REQ-024 When tracing is 0: valid_out SHALL be 0, valid_in SHALL be ignored, and no VRF writes SHALL occur.
REQ-025 Config: while tracing is 0 and configId equals PERSONAL_CONFIG_ID, each cycle SHALL consume one byte.
REQ-026 Config byte k SHALL go to table floor(k/MAX_CHAINS) (op, addr_rd, cond, cache, cache_addr) at entry k mod MAX_CHAINS.
REQ-027 Bytes at k >= 5*MAX_CHAINS SHALL be ignored; the counter SHALL hold at 5*MAX_CHAINS.
REQ-028 The byte counter SHALL clear in any cycle where configId differs from PERSONAL_CONFIG_ID or tracing is 1.
REQ-029 addr_rd and cache_addr SHALL use the low clog2(VRF_SIZE) bits only.

Reset
REQ-030 On reset: all outputs SHALL be 0; pipeline valids SHALL be 0; byte counter SHALL be 0; all firmware entries SHALL be 0 (pass, cond always, no cache); VRF SHALL be cleared to 0.
REQ-031 Reset asserted mid-config or mid-stream SHALL abort the operation; after release, data in flight SHALL not produce valid_out.

Structure
REQ-032 Package vvalu_pkg SHALL hold the op and cond enums, the config table index constants and the saturate function.
REQ-033 Per-lane arithmetic SHALL live in sub-module vvalu_lane, instantiated N times; the firmware tables and the VRF SHALL be register arrays in the top module.

Verification (DATA_WIDTH=16, FRAC_BITS=8, N=4)
REQ-034 op 1, addr_rd 0 after reset, input 0x0123 in all lanes -> 0x0123 two cycles later, overflow_out 0.
REQ-035 op 1, cache 1, addr_rd 2, cache_addr 2, three consecutive inputs of 0x0100 -> outputs 0x0100, 0x0200, 0x0300.
REQ-036 VRF[0]=0x7000, op 1, input 0x7000 -> output 0x7FFF with overflow 1; with SATURATE=0 -> output 0xE000 with overflow 1.
REQ-037 op 2, VRF lane 0x0180, input 0xFE00 -> output 0xFD00 (1.5 x -2.0 = -3.0).
REQ-038 cond 1, op 1, eof_in 0 -> output equals input; with eof_in[0]=1 -> sum.
REQ-039 Stream 20 config bytes, then 5 extra bytes, then pulse reset mid-stream on a repeat run -> tables match the first 20 bytes; after reset all tables are 0.

Source files
------------

// File: rtl/vvalu_pkg.sv
// Shared types and helpers for the saturating vector-vector ALU.
// Op/cond encodings, config table layout, condition decode and clamp function.
package vvalu_pkg;

  typedef enum logic [7:0] {
    OP_PASS    = 8'd0,
    OP_ADD     = 8'd1,
    OP_MUL     = 8'd2,
    OP_SUB     = 8'd3,
    OP_MAX     = 8'd4,
    OP_MIN     = 8'd5,
    OP_ABSDIFF = 8'd6
  } op_e;

  typedef enum logic [7:0] {
    COND_ALWAYS  = 8'd0,
    COND_EOF0_HI = 8'd1,
    COND_EOF0_LO = 8'd2,
    COND_BOF0_HI = 8'd3,
    COND_BOF0_LO = 8'd4,
    COND_EOF1_HI = 8'd5,
    COND_EOF1_LO = 8'd6,
    COND_BOF1_HI = 8'd7,
    COND_BOF1_LO = 8'd8
  } cond_e;

  // Config byte k lands in table k / MAX_CHAINS, in this order.
  localparam int unsigned NUM_TABLES     = 5;
  localparam int unsigned TBL_OP         = 0;
  localparam int unsigned TBL_ADDR_RD    = 1;
  localparam int unsigned TBL_COND       = 2;
  localparam int unsigned TBL_CACHE      = 3;
  localparam int unsigned TBL_CACHE_ADDR = 4;

  // Wide enough to hold any exact lane result for lane widths up to 64 bits.
  localparam int unsigned XW = 130;

  function automatic logic cond_holds(input logic [7:0] cond,
                                      input logic [1:0] eof,
                                      input logic [1:0] bof);
    logic hold;
    case (cond)
      COND_ALWAYS:  hold = 1'b1;
      COND_EOF0_HI: hold = eof[0];
      COND_EOF0_LO: hold = !eof[0];
      COND_BOF0_HI: hold = bof[0];
      COND_BOF0_LO: hold = !bof[0];
      COND_EOF1_HI: hold = eof[1];
      COND_EOF1_LO: hold = !eof[1];
      COND_BOF1_HI: hold = bof[1];
      COND_BOF1_LO: hold = !bof[1];
      default:      hold = 1'b0;
    endcase
    return hold;
  endfunction

  // Clamp x to a signed w-bit range when sat_en, else pass it for wrapping;
  // ovf reports whether x was outside that range.
  function automatic logic signed [XW-1:0] saturate(input logic signed [XW-1:0] x,
                                                    input int unsigned w,
                                                    input logic sat_en,
                                                    output logic ovf);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    logic signed [XW-1:0] res;
    hi  = (XW'(1) << (w - 1)) - XW'(1);
    lo  = -(XW'(1) << (w - 1));
    ovf = (x > hi) || (x < lo);
    res = x;
    if (sat_en && (x > hi)) res = hi;
    if (sat_en && (x < lo)) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/vvalu_lane.sv
// One lane of the vector ALU: combinational op on input lane and VRF operand,
// followed by saturation or wrap to the lane width.
module vvalu_lane
  import vvalu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned SATURATE   = 1
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [7:0]            i_op,
  input  logic                  i_cond_ok,
  output logic [DATA_WIDTH-1:0] o_res_c,
  output logic                  o_ovf_c
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [XW-1:0] w_a;
  logic signed [XW-1:0] w_b;
  logic signed [PW-1:0] w_prod;
  logic signed [XW-1:0] w_diff;
  logic signed [XW-1:0] w_exact;
  logic                 w_arith;
  logic                 w_sat_ovf;

  assign w_a    = XW'($signed(i_a));
  assign w_b    = XW'($signed(i_b));
  assign w_prod = PW'($signed(i_a)) * PW'($signed(i_b));
  assign w_diff = w_a - w_b;

  // Exact result; only add/mul/sub/absdiff can leave the lane range.
  always_comb begin
    w_exact = w_a;
    w_arith = 1'b0;
    if (i_cond_ok) begin
      case (i_op)
        OP_ADD: begin
          w_exact = w_a + w_b;
          w_arith = 1'b1;
        end
        OP_MUL: begin
          w_exact = XW'(w_prod >>> FRAC_BITS);
          w_arith = 1'b1;
        end
        OP_SUB: begin
          w_exact = w_diff;
          w_arith = 1'b1;
        end
        OP_MAX:  w_exact = (w_a > w_b) ? w_a : w_b;
        OP_MIN:  w_exact = (w_a < w_b) ? w_a : w_b;
        OP_ABSDIFF: begin
          w_exact = w_diff[XW-1] ? -w_diff : w_diff;
          w_arith = 1'b1;
        end
        default: w_exact = w_a;
      endcase
    end
  end

  always_comb begin
    w_sat_ovf = 1'b0;
    o_res_c   = DATA_WIDTH'(saturate(w_exact, DATA_WIDTH, SATURATE != 0, w_sat_ovf));
    o_ovf_c   = w_sat_ovf & w_arith;
  end

endmodule

// File: rtl/vector_vector_alu_sat.sv
// Two-stage saturating vector-vector ALU with per-chain firmware tables loaded
// from a config byte stream and a small vector register file for accumulation.
module vector_vector_alu_sat
  import vvalu_pkg::*;
#(
  parameter int unsigned N                  = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FRAC_BITS          = 16,
  parameter int unsigned MAX_CHAINS         = 4,
  parameter int unsigned VRF_SIZE           = 8,
  parameter int unsigned PERSONAL_CONFIG_ID = 0,
  parameter int unsigned SATURATE           = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         tracing,
  input  logic                                         valid_in,
  input  logic [1:0]                                   eof_in,
  input  logic [1:0]                                   bof_in,
  input  logic [((MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1)-1:0] chainId_in,
  input  logic [7:0]                                   configId,
  input  logic [7:0]                                   configData,
  input  logic [N*DATA_WIDTH-1:0]                      vector_in,
  output logic [N*DATA_WIDTH-1:0]                      vector_out,
  output logic                                         valid_out,
  output logic [1:0]                                   eof_out,
  output logic [1:0]                                   bof_out,
  output logic [((MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1)-1:0] chainId_out,
  output logic [N-1:0]                                 overflow_out
);

  localparam int unsigned CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int unsigned AW = (VRF_SIZE > 1) ? $clog2(VRF_SIZE) : 1;
  localparam int unsigned VW = N * DATA_WIDTH;
  localparam int unsigned TW = 3;

  logic [7:0]    r_fw [NUM_TABLES][MAX_CHAINS];
  logic [TW-1:0] r_cfg_tbl;
  logic [CW-1:0] r_cfg_ent;
  logic [VW-1:0] r_vrf [VRF_SIZE];

  logic          r_s1_valid;
  logic [VW-1:0] r_s1_vec;
  logic [1:0]    r_s1_eof;
  logic [1:0]    r_s1_bof;
  logic [CW-1:0] r_s1_chain;
  logic [7:0]    r_s1_op;
  logic [AW-1:0] r_s1_addr_rd;
  logic [7:0]    r_s1_cond;
  logic [7:0]    r_s1_cache;
  logic [AW-1:0] r_s1_cache_addr;

  logic          w_cfg_en;
  logic          w_cfg_wr;
  logic [7:0]    w_fw_op;
  logic [7:0]    w_fw_addr_rd;
  logic [7:0]    w_fw_cond;
  logic [7:0]    w_fw_cache;
  logic [7:0]    w_fw_cache_addr;
  logic [VW-1:0] w_operand;
  logic          w_cond_ok;
  logic [VW-1:0] w_result;
  logic [N-1:0]  w_ovf;
  logic          w_vrf_we;

  assign w_cfg_en = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
  assign w_cfg_wr = w_cfg_en && (r_cfg_tbl < TW'(NUM_TABLES));

  // Config byte counter split as (table, entry); parks at (NUM_TABLES, 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_tbl <= '0;
      r_cfg_ent <= '0;
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int c = 0; c < MAX_CHAINS; c++) begin
          r_fw[t][c] <= '0;
        end
      end
    end else if (!w_cfg_en) begin
      r_cfg_tbl <= '0;
      r_cfg_ent <= '0;
    end else if (w_cfg_wr) begin
      r_fw[r_cfg_tbl][r_cfg_ent] <= configData;
      if (r_cfg_ent == CW'(MAX_CHAINS - 1)) begin
        r_cfg_ent <= '0;
        r_cfg_tbl <= r_cfg_tbl + TW'(1);
      end else begin
        r_cfg_ent <= r_cfg_ent + CW'(1);
      end
    end
  end

  assign w_fw_op         = r_fw[TW'(TBL_OP)][chainId_in];
  assign w_fw_addr_rd    = r_fw[TW'(TBL_ADDR_RD)][chainId_in];
  assign w_fw_cond       = r_fw[TW'(TBL_COND)][chainId_in];
  assign w_fw_cache      = r_fw[TW'(TBL_CACHE)][chainId_in];
  assign w_fw_cache_addr = r_fw[TW'(TBL_CACHE_ADDR)][chainId_in];

  // Stage 1: capture the vector, its sideband and the chain's firmware entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid      <= 1'b0;
      r_s1_vec        <= '0;
      r_s1_eof        <= '0;
      r_s1_bof        <= '0;
      r_s1_chain      <= '0;
      r_s1_op         <= '0;
      r_s1_addr_rd    <= '0;
      r_s1_cond       <= '0;
      r_s1_cache      <= '0;
      r_s1_cache_addr <= '0;
    end else begin
      r_s1_valid      <= valid_in && tracing;
      r_s1_vec        <= vector_in;
      r_s1_eof        <= eof_in;
      r_s1_bof        <= bof_in;
      r_s1_chain      <= chainId_in;
      r_s1_op         <= w_fw_op;
      r_s1_addr_rd    <= AW'(w_fw_addr_rd);
      r_s1_cond       <= w_fw_cond;
      r_s1_cache      <= w_fw_cache;
      r_s1_cache_addr <= AW'(w_fw_cache_addr);
    end
  end

  assign w_operand = r_vrf[r_s1_addr_rd];
  assign w_cond_ok = cond_holds(r_s1_cond, r_s1_eof, r_s1_bof);

  for (genvar i = 0; i < N; i++) begin : g_lane
    vvalu_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .SATURATE   (SATURATE)
    ) u_lane (
      .i_a       (r_s1_vec[i*DATA_WIDTH +: DATA_WIDTH]),
      .i_b       (w_operand[i*DATA_WIDTH +: DATA_WIDTH]),
      .i_op      (r_s1_op),
      .i_cond_ok (w_cond_ok),
      .o_res_c   (w_result[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_ovf_c   (w_ovf[i])
    );
  end

  // Cache write happens regardless of cond, so a false cond copies the input.
  assign w_vrf_we = r_s1_valid && tracing && (r_s1_cache != 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < VRF_SIZE; a++) begin
        r_vrf[a] <= '0;
      end
    end else if (w_vrf_we) begin
      r_vrf[r_s1_cache_addr] <= w_result;
    end
  end

  // Stage 2: register results; payload only moves with a valid beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out    <= 1'b0;
      vector_out   <= '0;
      overflow_out <= '0;
      eof_out      <= '0;
      bof_out      <= '0;
      chainId_out  <= '0;
    end else begin
      valid_out <= r_s1_valid && tracing;
      if (r_s1_valid) begin
        vector_out   <= w_result;
        overflow_out <= w_ovf;
        eof_out      <= r_s1_eof;
        bof_out      <= r_s1_bof;
        chainId_out  <= r_s1_chain;
      end
    end
  end

endmodule

// File: tb/tb_vector_vector_alu_sat.sv
// Scoreboard bench: two instances (saturate and wrap) share stimulus; a monitor
// pops hand-computed expectations whenever the outputs are valid.
module tb_vector_vector_alu_sat;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned VW = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          tracing;
  logic          valid_in;
  logic [1:0]    eof_in;
  logic [1:0]    bof_in;
  logic [1:0]    chainId_in;
  logic [7:0]    configId;
  logic [7:0]    configData;
  logic [VW-1:0] vector_in;

  logic [VW-1:0] vector_out_s, vector_out_w;
  logic          valid_out_s, valid_out_w;
  logic [1:0]    eof_out_s, eof_out_w, bof_out_s, bof_out_w;
  logic [1:0]    chainId_out_s, chainId_out_w;
  logic [N-1:0]  overflow_out_s, overflow_out_w;

  vector_vector_alu_sat #(
    .N(N), .DATA_WIDTH(DW), .FRAC_BITS(8), .MAX_CHAINS(4), .VRF_SIZE(8),
    .PERSONAL_CONFIG_ID(0), .SATURATE(1)
  ) dut_s (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out_s), .valid_out(valid_out_s), .eof_out(eof_out_s),
    .bof_out(bof_out_s), .chainId_out(chainId_out_s), .overflow_out(overflow_out_s)
  );

  vector_vector_alu_sat #(
    .N(N), .DATA_WIDTH(DW), .FRAC_BITS(8), .MAX_CHAINS(4), .VRF_SIZE(8),
    .PERSONAL_CONFIG_ID(0), .SATURATE(0)
  ) dut_w (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out_w), .valid_out(valid_out_w), .eof_out(eof_out_w),
    .bof_out(bof_out_w), .chainId_out(chainId_out_w), .overflow_out(overflow_out_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vs;
    logic [VW-1:0] vw;
    logic [N-1:0]  ovf;
    logic [1:0]    eof;
    logic [1:0]    bof;
    logic [1:0]    chain;
    int unsigned   cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  p1[$];
  logic [7:0]  p2[$];
  logic [7:0]  p3[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] v4(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] sp(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [VW-1:0] v,
                      input logic [1:0] eof, input logic [1:0] bof,
                      input logic [VW-1:0] es, input logic [VW-1:0] ew,
                      input logic [N-1:0] eo);
    exp_t x;
    @(negedge clk);
    tracing    = 1'b1;
    configId   = 8'hFF;
    valid_in   = 1'b1;
    chainId_in = ch;
    vector_in  = v;
    eof_in     = eof;
    bof_in     = bof;
    x.vs = es; x.vw = ew; x.ovf = eo; x.eof = eof; x.bof = bof; x.chain = ch;
    x.cyc = cyc + 2;
    sb.push_back(x);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic cfg_stream(input logic [7:0] b[$], input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      valid_in   = 1'b0;
      tracing    = 1'b0;
      configId   = 8'h00;
      configData = b[i];
    end
  endtask

  task automatic drain(input string nm);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d outputs still pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every valid output beat must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_out_s || valid_out_w) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_out: valid_out_s=%0b valid_out_w=%0b vec=%h, expected no output",
                   valid_out_s, valid_out_w, vector_out_s);
        end else begin
          e = sb.pop_front();
          if (!valid_out_s || !valid_out_w || vector_out_s !== e.vs || vector_out_w !== e.vw ||
              overflow_out_s !== e.ovf || overflow_out_w !== e.ovf ||
              eof_out_s !== e.eof || bof_out_s !== e.bof || chainId_out_s !== e.chain ||
              eof_out_w !== e.eof || bof_out_w !== e.bof || chainId_out_w !== e.chain ||
              cyc != e.cyc) begin
            n_errors++;
            $display("FAIL out_chain%0d: sat=%h exp %h wrap=%h exp %h ovf_s=%b ovf_w=%b exp %b eof=%b exp %b bof=%b exp %b chain=%0d cyc=%0d exp %0d",
                     e.chain, vector_out_s, e.vs, vector_out_w, e.vw, overflow_out_s,
                     overflow_out_w, e.ovf, eof_out_s, e.eof, bof_out_s, e.bof,
                     chainId_out_s, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ops / addr_rd / cond / cache / cache_addr for chains 0..3, then 5 junk bytes
    p1 = '{8'd1, 8'd1, 8'd0, 8'd1,
           8'd0, 8'd2, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd1,
           8'd0, 8'd1, 8'd1, 8'd0,
           8'd0, 8'd2, 8'd0, 8'd0,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    p2 = '{8'd2, 8'd3, 8'd4, 8'd6,
           8'd2, 8'd2, 8'd2, 8'd2,
           8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0,
           8'd0, 8'd0, 8'd0, 8'd0};
    p3 = '{8'd1};

    reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = '0; bof_in = '0;
    chainId_in = '0; configId = 8'hFF; configData = '0; vector_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", 64'(valid_out_s), 64'd0);
    chk("rst_vector_out", 64'(vector_out_s), 64'd0);
    chk("rst_overflow_out", 64'(overflow_out_s), 64'd0);
    chk("rst_sideband", 64'({eof_out_s, bof_out_s, chainId_out_s}), 64'd0);
    reset = 1'b0;

    cfg_stream(p1, 25);
    // Basic add with empty VRF, then accumulation into VRF[2]
    send(2'd0, sp(16'h0123), 2'b00, 2'b00, sp(16'h0123), sp(16'h0123), 4'b0000);
    send(2'd1, sp(16'h0100), 2'b10, 2'b01, sp(16'h0100), sp(16'h0100), 4'b0000);
    send(2'd1, sp(16'h0100), 2'b00, 2'b00, sp(16'h0200), sp(16'h0200), 4'b0000);
    send(2'd1, sp(16'h0100), 2'b01, 2'b10, sp(16'h0300), sp(16'h0300), 4'b0000);
    send(2'd1, sp(16'hFE80), 2'b00, 2'b00, sp(16'h0180), sp(16'h0180), 4'b0000);
    // Load VRF[0] with 0x7000 via pass+cache, then overflow on add
    send(2'd2, sp(16'h7000), 2'b00, 2'b00, sp(16'h7000), sp(16'h7000), 4'b0000);
    send(2'd0, v4(16'h7000, 16'h1000, 16'h8000, 16'h0001), 2'b00, 2'b00,
         v4(16'h7FFF, 16'h7FFF, 16'hF000, 16'h7001),
         v4(16'hE000, 16'h8000, 16'hF000, 16'h7001), 4'b0011);
    // Conditional add on eof[0]
    send(2'd3, v4(16'h0010, 16'h0020, 16'h0030, 16'h8000), 2'b00, 2'b00,
         v4(16'h0010, 16'h0020, 16'h0030, 16'h8000),
         v4(16'h0010, 16'h0020, 16'h0030, 16'h8000), 4'b0000);
    send(2'd3, v4(16'h0010, 16'h0020, 16'h0030, 16'h8000), 2'b01, 2'b00,
         v4(16'h7010, 16'h7020, 16'h7030, 16'hF000),
         v4(16'h7010, 16'h7020, 16'h7030, 16'hF000), 4'b0000);
    send(2'd3, v4(16'h0010, 16'h0020, 16'h0030, 16'h8000), 2'b10, 2'b11,
         v4(16'h0010, 16'h0020, 16'h0030, 16'h8000),
         v4(16'h0010, 16'h0020, 16'h0030, 16'h8000), 4'b0000);
    idle(1);
    // valid_in while not tracing must be dropped
    @(negedge clk);
    tracing = 1'b0; configId = 8'hFF; valid_in = 1'b1; vector_in = sp(16'h5555);
    idle(1);
    drain("drain_phase1");

    cfg_stream(p2, 20);
    // mul / sub / max / absdiff against VRF[2] = 1.5
    send(2'd0, v4(16'hFE00, 16'h0001, 16'hFFFF, 16'h7FFF), 2'b00, 2'b00,
         v4(16'hFD00, 16'h0001, 16'hFFFE, 16'h7FFF),
         v4(16'hFD00, 16'h0001, 16'hFFFE, 16'hBFFE), 4'b1000);
    send(2'd1, v4(16'h0100, 16'h8000, 16'h0000, 16'h0200), 2'b00, 2'b00,
         v4(16'hFF80, 16'h8000, 16'hFE80, 16'h0080),
         v4(16'hFF80, 16'h7E80, 16'hFE80, 16'h0080), 4'b0010);
    send(2'd2, v4(16'h0100, 16'h0200, 16'h8000, 16'h7FFF), 2'b00, 2'b00,
         v4(16'h0180, 16'h0200, 16'h0180, 16'h7FFF),
         v4(16'h0180, 16'h0200, 16'h0180, 16'h7FFF), 4'b0000);
    send(2'd3, v4(16'h0100, 16'h8000, 16'h0180, 16'h7FFF), 2'b00, 2'b00,
         v4(16'h0080, 16'h7FFF, 16'h0000, 16'h7E7F),
         v4(16'h0080, 16'h8180, 16'h0000, 16'h7E7F), 4'b0010);
    idle(1);
    drain("drain_phase2");

    // Reset with a beat in flight: it must never reach valid_out
    @(negedge clk);
    tracing = 1'b1; valid_in = 1'b1; chainId_in = 2'd0; vector_in = sp(16'h1234);
    @(posedge clk);
    #1 reset = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Reset in the middle of a config stream wipes all tables and the VRF
    cfg_stream(p2, 7);
    @(posedge clk);
    #1 reset = 1'b1;
    configId = 8'hFF;
    repeat (2) @(negedge clk);
    chk("midcfg_rst_valid_out", 64'(valid_out_s), 64'd0);
    chk("midcfg_rst_vector_out", 64'(vector_out_s), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      send(2'(c), v4(16'h1111, 16'h8000, 16'h7FFF, 16'hFE00), 2'b00, 2'b00,
           v4(16'h1111, 16'h8000, 16'h7FFF, 16'hFE00),
           v4(16'h1111, 16'h8000, 16'h7FFF, 16'hFE00), 4'b0000);
    end
    idle(1);
    drain("drain_after_reset");

    // Chain 0 becomes add from VRF[0]; a cleared VRF makes it an identity
    cfg_stream(p3, 1);
    send(2'd0, v4(16'h0001, 16'h0002, 16'h8000, 16'h7FFF), 2'b00, 2'b00,
         v4(16'h0001, 16'h0002, 16'h8000, 16'h7FFF),
         v4(16'h0001, 16'h0002, 16'h8000, 16'h7FFF), 4'b0000);
    idle(1);
    drain("drain_vrf_clear");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
